operand_fetch: RTL and testbench

//  Register-read stage sitting directly upstream of the execute stage. It owns the 32-entry

---
 rtl/operand_fetch_pkg.sv | 27 ++
 rtl/operand_fetch_reg_file.sv | 27 ++
 rtl/operand_fetch.sv | 108 ++++++++++
 tb/tb_operand_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared widths, the execute-stage request bundle and a source-match helper
// for the operand_fetch register-read stage.
package operand_fetch_pkg;

  localparam int ADDR   = 32;
  localparam int W_IMM  = 16;
  localparam int W_OPR  = 32;
  localparam int W_RD   = 5;
  localparam int D_INFO = 16;
  localparam int NREG   = 2 ** W_RD;

  typedef struct packed {
    logic [ADDR-1:0]   pc;
    logic [W_IMM-1:0]  imm;
    logic [D_INFO-1:0] d_info;
    logic [W_OPR-1:0]  opr0;
    logic [W_OPR-1:0]  opr1;
    logic [W_RD-1:0]   rd;
    logic              wr;
  } ex_req_t;

  function automatic logic src_hit(input logic use_s, input logic [W_RD-1:0] rs,
                                   input logic [W_RD-1:0] r);
    return use_s & (rs == r);
  endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// 2**W_RD x W_OPR register file: two asynchronous read ports, one synchronous
// write port, synchronous clear on reset.
module reg_file
  import operand_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [W_RD-1:0]  ra0,
  input  logic [W_RD-1:0]  ra1,
  output logic [W_OPR-1:0] rdata0,
  output logic [W_OPR-1:0] rdata1,
  input  logic             we,
  input  logic [W_RD-1:0]  wa,
  input  logic [W_OPR-1:0] wdata
);

  logic [NREG-1:0][W_OPR-1:0] mem;

  always_ff @(posedge clk) begin
    if (reset)   mem <= '0;
    else if (we) mem[wa] <= wdata;
  end

  assign rdata0 = mem[ra0];
  assign rdata1 = mem[ra1];

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage feeding execute: RF read, RAW hazard bubbles, stage register.
// Optional same-cycle write-back forwarding: define OPERAND_FETCH_BYPASS_EN.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              v_i,
  output logic              stall_o,
  input  logic [ADDR-1:0]   pc_i,
  input  logic [W_IMM-1:0]  imm_i,
  input  logic [D_INFO-1:0] d_info_i,
  input  logic [W_RD-1:0]   rs0_i,
  input  logic              use0_i,
  input  logic [W_RD-1:0]   rs1_i,
  input  logic              use1_i,
  input  logic [W_RD-1:0]   rd_i,
  input  logic              wr_i,
  input  logic              flush_i,
  output logic              v_o,
  input  logic              stall_i,
  output logic [ADDR-1:0]   pc_o,
  output logic [W_IMM-1:0]  imm_o,
  output logic [D_INFO-1:0] d_info_o,
  output logic [W_OPR-1:0]  opr0_o,
  output logic [W_OPR-1:0]  opr1_o,
  output logic [W_RD-1:0]   wb_r_o,
  output logic              wr_o,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   wb_r_i,
  input  logic [W_OPR-1:0]  wb_data_i
);

  logic [W_OPR-1:0] rf0, rf1, src0, src1;
  logic             adv, haz, haz_ex, haz_wb;
  logic             v_q;
  ex_req_t          req_d, req_q;

  reg_file u_rf (
    .clk    (clk),
    .reset  (reset),
    .ra0    (rs0_i),
    .ra1    (rs1_i),
    .rdata0 (rf0),
    .rdata1 (rf1),
    .we     (wb_i),
    .wa     (wb_r_i),
    .wdata  (wb_data_i)
  );

  assign adv    = ~stall_i | ~v_q;
  assign haz_ex = v_i & v_q & req_q.wr &
                  (src_hit(use0_i, rs0_i, req_q.rd) | src_hit(use1_i, rs1_i, req_q.rd));

`ifdef OPERAND_FETCH_BYPASS_EN
  assign src0   = (wb_i && wb_r_i == rs0_i) ? wb_data_i : rf0;
  assign src1   = (wb_i && wb_r_i == rs1_i) ? wb_data_i : rf1;
  assign haz_wb = 1'b0;
`else
  // Without forwarding a write landing this edge is invisible to the async read.
  assign src0   = rf0;
  assign src1   = rf1;
  assign haz_wb = v_i & wb_i &
                  (src_hit(use0_i, rs0_i, wb_r_i) | src_hit(use1_i, rs1_i, wb_r_i));
`endif

  assign haz     = haz_ex | haz_wb;
  assign stall_o = reset ? 1'b0 : flush_i ? 1'b0 : (~adv | haz);

  always_comb begin
    req_d        = '0;
    req_d.pc     = pc_i;
    req_d.imm    = imm_i;
    req_d.d_info = d_info_i;
    req_d.opr0   = src0;
    req_d.opr1   = src1;
    req_d.rd     = rd_i;
    req_d.wr     = wr_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= 1'b0;
      req_q <= '0;
    end else if (flush_i) begin
      v_q      <= 1'b0;
      req_q.wr <= 1'b0;
    end else if (adv) begin
      if (haz) begin
        v_q      <= 1'b0;
        req_q.wr <= 1'b0;
      end else begin
        v_q   <= v_i;
        req_q <= req_d;
      end
    end
  end

  assign v_o      = v_q;
  assign pc_o     = req_q.pc;
  assign imm_o    = req_q.imm;
  assign d_info_o = req_q.d_info;
  assign opr0_o   = req_q.opr0;
  assign opr1_o   = req_q.opr1;
  assign wb_r_o   = req_q.rd;
  assign wr_o     = req_q.wr;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios then randomized traffic
// against a register-array reference model.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic              clk = 1'b0;
  logic              reset, v_i, stall_o, use0_i, use1_i, wr_i, flush_i, v_o, stall_i;
  logic              wr_o, wb_i;
  logic [ADDR-1:0]   pc_i, pc_o;
  logic [W_IMM-1:0]  imm_i, imm_o;
  logic [D_INFO-1:0] d_info_i, d_info_o;
  logic [W_RD-1:0]   rs0_i, rs1_i, rd_i, wb_r_o, wb_r_i;
  logic [W_OPR-1:0]  opr0_o, opr1_o, wb_data_i;

  operand_fetch dut (
    .clk(clk), .reset(reset), .v_i(v_i), .stall_o(stall_o), .pc_i(pc_i), .imm_i(imm_i),
    .d_info_i(d_info_i), .rs0_i(rs0_i), .use0_i(use0_i), .rs1_i(rs1_i), .use1_i(use1_i),
    .rd_i(rd_i), .wr_i(wr_i), .flush_i(flush_i), .v_o(v_o), .stall_i(stall_i),
    .pc_o(pc_o), .imm_o(imm_o), .d_info_o(d_info_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
    .wb_r_o(wb_r_o), .wr_o(wr_o), .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR-1:0]   pc;
    logic [W_IMM-1:0]  imm;
    logic [D_INFO-1:0] d_info;
    logic [W_OPR-1:0]  opr0;
    logic [W_OPR-1:0]  opr1;
    logic [W_RD-1:0]   rd;
    logic              wr;
  } exp_t;

  exp_t             q[$];
  logic [W_OPR-1:0] rf[NREG];
  // Reference view of the instruction sitting at execute's input.
  logic             m_v, m_wr;
  logic [W_RD-1:0]  m_rd;
  logic             last_stall;
  int               n_tests, n_fail, stall_cnt;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam int RAW_STALLS = 1;
  localparam int SAME_STALLS = 0;
`else
  localparam int RAW_STALLS = 2;
  localparam int SAME_STALLS = 1;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic hit(input logic u, input logic [W_RD-1:0] rs, input logic [W_RD-1:0] r);
    return u && (rs == r);
  endfunction

  function automatic logic [W_OPR-1:0] read_src(input logic [W_RD-1:0] rs);
`ifdef OPERAND_FETCH_BYPASS_EN
    if (wb_i && wb_r_i == rs) return wb_data_i;
`endif
    return rf[rs];
  endfunction

  // One clock: check stall_o/v_o against the model at negedge, advance model, drive after edge.
  task automatic step();
    logic adv, haz, es;
    exp_t e;
    @(negedge clk);
    if (reset) begin
      check("stall_in_reset", stall_o, 1'b0);
      m_v = 0; m_wr = 0; m_rd = 0; q.delete(); last_stall = 0;
      for (int i = 0; i < NREG; i++) rf[i] = '0;
    end else begin
      check("v_o", v_o, m_v);
      adv = !stall_i || !m_v;
      haz = v_i && m_v && m_wr && (hit(use0_i, rs0_i, m_rd) || hit(use1_i, rs1_i, m_rd));
`ifndef OPERAND_FETCH_BYPASS_EN
      haz = haz || (v_i && wb_i && (hit(use0_i, rs0_i, wb_r_i) || hit(use1_i, rs1_i, wb_r_i)));
`endif
      es = flush_i ? 1'b0 : (!adv || haz);
      check("stall_o", stall_o, es);
      if (stall_o) stall_cnt++;
      last_stall = es;
      if (flush_i) begin
        m_v = 0; m_wr = 0; q.delete();
      end else if (adv) begin
        if (haz) begin
          m_v = 0; m_wr = 0;
        end else begin
          m_v = v_i; m_wr = wr_i; m_rd = rd_i;
          if (v_i) begin
            e.pc = pc_i; e.imm = imm_i; e.d_info = d_info_i; e.rd = rd_i; e.wr = wr_i;
            e.opr0 = read_src(rs0_i); e.opr1 = read_src(rs1_i);
            q.push_back(e);
          end
        end
      end
      if (wb_i) rf[wb_r_i] = wb_data_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [ADDR-1:0] pc, input logic u0, input logic [W_RD-1:0] r0,
                       input logic u1, input logic [W_RD-1:0] r1, input logic w,
                       input logic [W_RD-1:0] rd);
    v_i = 1; pc_i = pc; imm_i = pc[15:0] ^ 16'h5a5a; d_info_i = ~pc[15:0];
    use0_i = u0; rs0_i = r0; use1_i = u1; rs1_i = r1; wr_i = w; rd_i = rd;
  endtask

  task automatic new_random();
    logic [31:0] r;
    r = $urandom;
    v_i = (r[1:0] != 0);
    pc_i = $urandom; imm_i = 16'($urandom); d_info_i = 16'($urandom);
    rs0_i = 5'($urandom_range(0, 7)); rs1_i = 5'($urandom_range(0, 7));
    rd_i = 5'($urandom_range(0, 7));
    use0_i = r[2]; use1_i = r[3]; wr_i = r[4];
  endtask

  // Monitor: execute consumes the held instruction when v_o & ~stall_i.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && v_o === 1'b1 && !stall_i && !flush_i) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_v_o: got v_o=1 expected no pending instruction");
        end else begin
          e = q.pop_front();
          check("opr0", opr0_o, e.opr0);
          check("opr1", opr1_o, e.opr1);
          check("pc_imm_dinfo", {pc_o, imm_o, d_info_o}, {e.pc, e.imm, e.d_info});
          check("rd_wr", {wb_r_o, wr_o}, {e.rd, e.wr});
        end
      end
    end
  end

  initial begin
    reset = 1; v_i = 0; pc_i = 0; imm_i = 0; d_info_i = 0; rs0_i = 0; rs1_i = 0; rd_i = 0;
    use0_i = 0; use1_i = 0; wr_i = 0; flush_i = 0; stall_i = 0; wb_i = 0; wb_r_i = 0;
    wb_data_i = 0; n_tests = 0; n_fail = 0; stall_cnt = 0; last_stall = 0;
    m_v = 0; m_wr = 0; m_rd = 0;
    step(); step();
    check("rst_v_o", v_o, 1'b0);
    check("rst_wr_o", wr_o, 1'b0);
    check("rst_opr0", opr0_o, '0);
    reset = 0;

    // Read after reset returns zero.
    issue(32'h10, 1, 5, 0, 0, 0, 0); step();
    check("t1_opr0", opr0_o, '0);
    v_i = 0; step();

    // Write-back then read.
    wb_i = 1; wb_r_i = 3; wb_data_i = 32'h1234_5678; step();
    wb_i = 0; step();
    issue(32'h20, 0, 0, 1, 3, 0, 0); step();
    check("t2_opr1", opr1_o, 32'h1234_5678);
    v_i = 0; step();

    // RAW on the instruction entering execute.
    issue(32'h30, 0, 0, 0, 0, 1, 4); step();
    issue(32'h34, 1, 4, 0, 0, 0, 0); stall_cnt = 0; step();
    check("t3_bubble", v_o, 1'b0);
    wb_i = 1; wb_r_i = 4; wb_data_i = 32'hDEAD_BEEF; step();
    wb_i = 0;
    for (int i = 0; i < 4 && last_stall; i++) step();
    check("t3_opr0", opr0_o, 32'hDEAD_BEEF);
    check("t3_stalls", stall_cnt, RAW_STALLS);
    v_i = 0; step();

    // Execute stall holds outputs.
    issue(32'h40, 0, 0, 0, 0, 0, 0); step();
    issue(32'h44, 0, 0, 0, 0, 0, 0); stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_pc", pc_o, 32'h40);
    end
    stall_i = 0; step();
    check("t4_next_pc", pc_o, 32'h44);
    v_i = 0; step();

    // Flush during hazard and execute stall.
    issue(32'h50, 0, 0, 0, 0, 1, 6); step();
    issue(32'h54, 0, 0, 1, 6, 0, 0); stall_i = 1; flush_i = 1; step();
    check("t5_v_o", v_o, 1'b0);
    flush_i = 0; stall_i = 0; v_i = 0; step();

    // Same-cycle write-back and read.
    wb_i = 1; wb_r_i = 7; wb_data_i = 32'hA5A5_0001;
    issue(32'h60, 1, 7, 0, 0, 0, 0); stall_cnt = 0; step();
    wb_i = 0;
    for (int i = 0; i < 4 && last_stall; i++) step();
    check("t6_opr0", opr0_o, 32'hA5A5_0001);
    check("t6_stalls", stall_cnt, SAME_STALLS);
    v_i = 0; step();

    // Reset while a hazard stall is pending.
    issue(32'h70, 0, 0, 0, 0, 1, 2); step();
    issue(32'h74, 1, 2, 0, 0, 0, 0); reset = 1; step();
    reset = 0; v_i = 0; step();
    check("t7_v_o", v_o, 1'b0);
    check("t7_rf_cleared_wr", wr_o, 1'b0);

    // Randomized traffic; decode holds its instruction while stalled.
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) new_random();
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 19) == 0);
      wb_i = ($urandom_range(0, 2) == 0);
      wb_r_i = 5'($urandom_range(0, 7));
      wb_data_i = $urandom;
      reset = ($urandom_range(0, 399) == 0);
      step();
    end

    reset = 0; v_i = 0; stall_i = 0; flush_i = 0; wb_i = 0;
    for (int i = 0; i < 3; i++) step();
    check("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
